// File: rtl/seq_101_tx.sv
// -----------------------------------------------------------------------------
// seq_101_tx
// Serial pattern transmitter feeding the "101" sequence detector. A start
// request captures a pattern word, a bit count and a repeat count, then the
// low iLEN bits of the pattern are shifted out MSB-first, one bit per clock.
// Extra frames (iREPEAT of them) follow the first, separated by GAP low
// cycles. A one-cycle oDONE pulse marks the end of the whole job.
//
// Parameters
//   WIDTH   pattern register width in bits (>= 2)
//   CNT_W   width of the repeat count (total frames = iREPEAT + 1)
//   GAP     low idle cycles between repeated frames (0 = back-to-back)
//
// Ports
//   iCLK      in   1        clock, all logic on the rising edge
//   iRST      in   1        synchronous active-low reset
//   iSTART    in   1        job request, honoured only while not busy
//   iPATTERN  in   WIDTH    pattern word, bit iLEN-1 is sent first
//   iLEN      in   LEN_W    bits per frame; 0 ignores the start, >WIDTH clamps
//   iREPEAT   in   CNT_W    additional frames after the first
//   oOUT      out  1        serial data bit (registered)
//   oFIRST    out  1        high alongside the first bit of each frame
//   oBUSY     out  1        high while a frame bit or gap bit is on oOUT
//   oDONE     out  1        one-cycle pulse after the last bit of the job
// -----------------------------------------------------------------------------
module seq_101_tx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4,
    parameter int GAP   = 2
) (
    input  logic                         iCLK,
    input  logic                         iRST,
    input  logic                         iSTART,
    input  logic [WIDTH-1:0]             iPATTERN,
    input  logic [$clog2(WIDTH+1)-1:0]   iLEN,
    input  logic [CNT_W-1:0]             iREPEAT,
    output logic                         oOUT,
    output logic                         oFIRST,
    output logic                         oBUSY,
    output logic                         oDONE
);

    localparam int LEN_W = $clog2(WIDTH + 1);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(WIDTH);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] GAPS  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] patReg;
    logic [LEN_W-1:0] lenReg;
    logic [LEN_W-1:0] bitIdx;
    logic [CNT_W-1:0] frameCnt;
    logic [GAP_W-1:0] gapCnt;

    logic [LEN_W-1:0] lenClamped;
    logic [LEN_W-1:0] startIdx;
    logic [LEN_W-1:0] firstIdx;
    logic             startOk;

    // Selecting a bit by shifting keeps the index width independent of the
    // pattern width, so lengths up to WIDTH (which needs an extra index bit)
    // are handled without a narrowing select.
    function automatic logic bitAt(input logic [WIDTH-1:0] pat,
                                   input logic [LEN_W-1:0] idx);
        logic [WIDTH-1:0] shifted;
        shifted = pat >> idx;
        return shifted[0];
    endfunction

    // Request qualification and the index of the first bit of a frame,
    // both for a freshly requested job and for repeats of the captured one.
    always_comb begin
        lenClamped = (iLEN > MAX_LEN) ? MAX_LEN : iLEN;
        startOk    = iSTART && (iLEN != '0);
        startIdx   = lenClamped - LEN_W'(1);
        firstIdx   = lenReg - LEN_W'(1);
    end

    // Main sequencer. Every output is computed together with the state it
    // belongs to, so what is registered here appears on the pins in the
    // following cycle. A start accepted in the DONE cycle chains directly into
    // the next job with no dead cycle.
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            state    <= IDLE;
            patReg   <= '0;
            lenReg   <= '0;
            bitIdx   <= '0;
            frameCnt <= '0;
            gapCnt   <= '0;
            oOUT     <= 1'b0;
            oFIRST   <= 1'b0;
            oBUSY    <= 1'b0;
            oDONE    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    state  <= IDLE;
                    oOUT   <= 1'b0;
                    oFIRST <= 1'b0;
                    oBUSY  <= 1'b0;
                    oDONE  <= 1'b0;
                    if (startOk) begin
                        patReg   <= iPATTERN;
                        lenReg   <= lenClamped;
                        frameCnt <= iREPEAT;
                        bitIdx   <= startIdx;
                        oOUT     <= bitAt(iPATTERN, startIdx);
                        oFIRST   <= 1'b1;
                        oBUSY    <= 1'b1;
                        state    <= SHIFT;
                    end
                end

                SHIFT: begin
                    oFIRST <= 1'b0;
                    if (bitIdx != '0) begin
                        bitIdx <= bitIdx - LEN_W'(1);
                        oOUT   <= bitAt(patReg, bitIdx - LEN_W'(1));
                    end else if (frameCnt != '0) begin
                        frameCnt <= frameCnt - CNT_W'(1);
                        if (GAP == 0) begin
                            bitIdx <= firstIdx;
                            oOUT   <= bitAt(patReg, firstIdx);
                            oFIRST <= 1'b1;
                        end else begin
                            state  <= GAPS;
                            gapCnt <= GAP_LAST;
                            oOUT   <= 1'b0;
                        end
                    end else begin
                        state <= DONE;
                        oOUT  <= 1'b0;
                        oBUSY <= 1'b0;
                        oDONE <= 1'b1;
                    end
                end

                GAPS: begin
                    if (gapCnt == '0) begin
                        state  <= SHIFT;
                        bitIdx <= firstIdx;
                        oOUT   <= bitAt(patReg, firstIdx);
                        oFIRST <= 1'b1;
                    end else begin
                        gapCnt <= gapCnt - GAP_W'(1);
                    end
                end

                default: begin
                    state  <= IDLE;
                    oOUT   <= 1'b0;
                    oFIRST <= 1'b0;
                    oBUSY  <= 1'b0;
                    oDONE  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_101_tx.sv
// -----------------------------------------------------------------------------
// tb_seq_101_tx
// Drives two transmitters (GAP=2 and GAP=0) from the same inputs and compares
// their outputs every cycle against a reference that expands each accepted
// job into the full list of expected per-cycle output tuples.
// -----------------------------------------------------------------------------
module tb_seq_101_tx;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int LEN_W = $clog2(WIDTH + 1);

    logic             clock = 1'b0;
    logic             resetN;
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [CNT_W-1:0] repeatCnt;

    logic outA, firstA, busyA, doneA;
    logic outB, firstB, busyB, doneB;

    int checks = 0;
    int errors = 0;

    // Expected tuples {out, first, busy, done}, one per future cycle.
    logic [3:0] qA[$];
    logic [3:0] qB[$];
    logic [3:0] curA;
    logic [3:0] curB;

    seq_101_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP(2)) dutA (
        .iCLK(clock), .iRST(resetN), .iSTART(start), .iPATTERN(pattern),
        .iLEN(len), .iREPEAT(repeatCnt),
        .oOUT(outA), .oFIRST(firstA), .oBUSY(busyA), .oDONE(doneA)
    );

    seq_101_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP(0)) dutB (
        .iCLK(clock), .iRST(resetN), .iSTART(start), .iPATTERN(pattern),
        .iLEN(len), .iREPEAT(repeatCnt),
        .oOUT(outB), .oFIRST(firstB), .oBUSY(busyB), .oDONE(doneB)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [3:0] obs,
                               input logic [3:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s out/first/busy/done got %b want %b at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    // Expand one job into its complete output sequence.
    task automatic pushJob(input int gap, input bit toB);
        logic [3:0] job[$];
        int effLen;
        effLen = (int'(len) > WIDTH) ? WIDTH : int'(len);
        for (int f = 0; f <= int'(repeatCnt); f++) begin
            for (int b = effLen - 1; b >= 0; b--)
                job.push_back({pattern[b], (b == effLen - 1), 1'b1, 1'b0});
            if (f < int'(repeatCnt))
                for (int g = 0; g < gap; g++)
                    job.push_back(4'b0010);
        end
        job.push_back(4'b0001);
        foreach (job[i]) begin
            if (toB) qB.push_back(job[i]);
            else     qA.push_back(job[i]);
        end
    endtask

    // An empty queue means the transmitter is idle or in its DONE cycle,
    // which are exactly the cycles in which a new start is honoured.
    task automatic modelStep();
        if (!resetN) begin
            qA.delete();
            qB.delete();
            curA = 4'b0;
            curB = 4'b0;
        end else begin
            if (qA.size() == 0 && start && len != '0) pushJob(2, 1'b0);
            if (qB.size() == 0 && start && len != '0) pushJob(0, 1'b1);
            curA = (qA.size() != 0) ? qA.pop_front() : 4'b0;
            curB = (qB.size() != 0) ? qB.pop_front() : 4'b0;
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [WIDTH-1:0] pat,
                                 input logic [LEN_W-1:0] ln,
                                 input logic [CNT_W-1:0] rep, input logic rst);
        start     = st;
        pattern   = pat;
        len       = ln;
        repeatCnt = rep;
        resetN    = rst;
        @(posedge clock);
        modelStep();
        #1;
        checkOutput("gap2", {outA, firstA, busyA, doneA}, curA);
        checkOutput("gap0", {outB, firstB, busyB, doneB}, curB);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, $urandom, LEN_W'($urandom), CNT_W'($urandom), 1'b1);
    endtask

    initial begin
        $display("[TB] start");
        start = 1'b0; pattern = '0; len = '0; repeatCnt = '0; resetN = 1'b0;

        applyStimulus(1'b0, 8'h00, 4'd0, 4'd0, 1'b0);
        applyStimulus(1'b0, 8'h00, 4'd0, 4'd0, 1'b0);
        idle(2);

        applyStimulus(1'b1, 8'h05, 4'd3, 4'd0, 1'b1);
        idle(6);

        applyStimulus(1'b1, 8'h05, 4'd3, 4'd1, 1'b1);
        idle(12);

        applyStimulus(1'b1, 8'hA5, 4'd0, 4'd0, 1'b1);
        idle(3);
        applyStimulus(1'b1, 8'hA5, 4'd15, 4'd0, 1'b1);
        idle(12);

        for (int i = 0; i < 10; i++)
            applyStimulus(1'b1, 8'h05, 4'd3, 4'd0, 1'b1);
        idle(8);

        applyStimulus(1'b1, 8'h05, 4'd3, 4'd0, 1'b1);
        applyStimulus(1'b0, 8'h00, 4'd0, 4'd0, 1'b1);
        applyStimulus(1'b0, 8'h00, 4'd0, 4'd0, 1'b0);
        idle(8);

        applyStimulus(1'b1, 8'h02, 4'd2, 4'd15, 1'b1);
        idle(70);

        for (int i = 0; i < 800; i++) begin
            applyStimulus(
                ($urandom_range(0, 3) == 0),
                WIDTH'($urandom),
                LEN_W'($urandom_range(0, 15)),
                ($urandom_range(0, 9) == 0) ? CNT_W'($urandom) : CNT_W'($urandom_range(0, 2)),
                ($urandom_range(0, 79) != 0));
        end
        idle(80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
